// File: rtl/ram_arb_pkg.sv
// Shared opcodes and FSM state encoding for the RAM command-port arbiter.
// Optional read watchdog is enabled by defining RAM_ARB_TIMEOUT_EN.
package ram_arb_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWNED   = 2'b01,
        WAIT_RD = 2'b10
    } arb_state_e;

endpackage

// File: rtl/ram_arb_wdog.sv
// Read watchdog: counts cycles spent waiting for RAM read data.
// Only instantiated when RAM_ARB_TIMEOUT_EN is defined.
module ram_arb_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Wait counter, cleared on entry and saturating at TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else if (i_clear) begin
            r_count <= {CW{1'b0}};
        end else if (i_enable && (r_count != CW'(TIMEOUT))) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Expiry is flagged in the cycle whose increment makes the count reach TIMEOUT
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the shared RAM command port with grant locking.
// Define RAM_ARB_TIMEOUT_EN to add the read watchdog (rsp_err on expiry).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [ADDR_SIZE+1:0]   req0_word,
    input  logic                   req0_lock,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_SIZE+1:0]   req1_word,
    input  logic                   req1_lock,
    output logic                   req1_ready,
    output logic                   rsp0_valid,
    output logic                   rsp1_valid,
    output logic [ADDR_SIZE-1:0]   rsp_data,
    output logic                   rsp_err,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid
);
    localparam int CW = ADDR_SIZE + 2;

    arb_state_e     r_state;
    logic           r_rr_ptr;
    logic           r_owner;
    logic           r_rd_lock;

    logic           w_win;
    logic           w_acc;
    logic           w_acc_id;
    logic [CW-1:0]  w_acc_word;
    logic           w_acc_lock;
    logic [1:0]     w_acc_op;
    logic           w_expired;

    // Winner when nobody owns the port; rr_ptr only matters on contention
    always_comb begin
        if (req0_valid && !req1_valid) begin
            w_win = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_win = 1'b1;
        end else begin
            w_win = r_rr_ptr;
        end
    end

    // Ready decode from state, owner and winner
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = ~w_win;
                req1_ready = w_win;
            end
            OWNED: begin
                req0_ready = ~r_owner;
                req1_ready = r_owner;
            end
            WAIT_RD: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
            end
            default: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
            end
        endcase
    end

    assign w_acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_acc_id   = req1_valid && req1_ready;
    assign w_acc_word = w_acc_id ? req1_word : req0_word;
    assign w_acc_lock = w_acc_id ? req1_lock : req0_lock;
    assign w_acc_op   = w_acc_word[CW-1 -: 2];

`ifdef RAM_ARB_TIMEOUT_EN
    logic w_rd_entry;
    logic w_in_wait;

    assign w_rd_entry = w_acc && (w_acc_op == CMD_RD_DATA);
    assign w_in_wait  = (r_state == WAIT_RD);

    ram_arb_wdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_rd_entry),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Arbitration FSM with registered RAM strobe and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_owner      <= 1'b0;
            r_rd_lock    <= 1'b0;
            ram_din      <= {CW{1'b0}};
            ram_rx_valid <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_data     <= {ADDR_SIZE{1'b0}};
            rsp_err      <= 1'b0;
        end else begin
            ram_rx_valid <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_err      <= 1'b0;
            case (r_state)
                IDLE, OWNED: begin
                    if (w_acc) begin
                        ram_rx_valid <= 1'b1;
                        ram_din      <= w_acc_word;
                        r_owner      <= w_acc_id;
                        if (w_acc_op == CMD_RD_DATA) begin
                            r_state   <= WAIT_RD;
                            r_rd_lock <= w_acc_lock;
                        end else if (w_acc_lock) begin
                            r_state <= OWNED;
                        end else begin
                            r_state  <= IDLE;
                            r_rr_ptr <= ~w_acc_id;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                WAIT_RD: begin
                    // Real data wins over a coincident watchdog expiry
                    if (ram_tx_valid || w_expired) begin
                        rsp0_valid <= ~r_owner;
                        rsp1_valid <= r_owner;
                        rsp_data   <= ram_tx_valid ? ram_dout : {ADDR_SIZE{1'b0}};
                        rsp_err    <= ~ram_tx_valid;
                        if (r_rd_lock) begin
                            r_state <= OWNED;
                        end else begin
                            r_state  <= IDLE;
                            r_rr_ptr <= ~r_owner;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus pushes expected RAM commands
// and responses; a monitor pops and compares when the DUT strobes an output.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0] req0_word = 10'h000, req1_word = 10'h000;
    logic       req0_lock = 1'b0, req1_lock = 1'b0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit ram_mute = 1'b0;

    typedef struct { logic [9:0] word; int cyc; } cmd_t;
    typedef struct { logic port; logic [7:0] data; logic err; int cyc; } rsp_t;
    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];

    ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_word(req0_word), .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_word(req1_word), .req1_lock(req1_lock), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: address/data registers, read data one cycle after the read-data strobe
    logic [7:0] mem [256];
    logic [7:0] m_waddr = 8'h00, m_raddr = 8'h00;
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00:   m_waddr <= ram_din[7:0];
                2'b01:   mem[m_waddr] <= ram_din[7:0];
                2'b10:   m_raddr <= ram_din[7:0];
                default: begin
                    ram_tx_valid <= !ram_mute;
                    ram_dout     <= mem[m_raddr];
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one word on port p, wait for acceptance and queue expectations
    task automatic send(input int p, input logic [9:0] w, input logic lk, input logic chk_out,
                        input logic [7:0] rdata, input logic rerr, input int rlat, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        if (p == 0) begin req0_word = w; req0_lock = lk; req0_valid = 1'b1; end
        else        begin req1_word = w; req1_lock = lk; req1_valid = 1'b1; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                done = 1'b1;
                acc  = cyc;
                if (chk_out) begin
                    exp_cmd.push_back('{w, cyc + 1});
                    if (w[9:8] == 2'b11) exp_rsp.push_back('{p[0], rdata, rerr, cyc + rlat});
                end
            end
            @(posedge clk);
            #1;
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL accept_timeout port=%0d word=%h got=not_accepted expected=accepted", p, w);
        end
    endtask

    // Monitor: pop and compare whenever the DUT strobes a command or a response
    cmd_t ce;
    rsp_t re;
    initial begin
        forever begin
            @(negedge clk);
            if (ram_rx_valid) begin
                checks++;
                if (exp_cmd.size() == 0) begin
                    fails++;
                    $display("FAIL ram_cmd_unexpected got=%h@%0d expected=none", ram_din, cyc);
                end else begin
                    ce = exp_cmd.pop_front();
                    if (ram_din !== ce.word || cyc != ce.cyc) begin
                        fails++;
                        $display("FAIL ram_cmd got=%h@%0d expected=%h@%0d", ram_din, cyc, ce.word, ce.cyc);
                    end
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (rsp0_valid && rsp1_valid) begin
                    fails++;
                    $display("FAIL rsp_both got=both expected=one");
                end else if (exp_rsp.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected got=port%0d data=%h@%0d expected=none", rsp1_valid, rsp_data, cyc);
                end else begin
                    re = exp_rsp.pop_front();
                    if (rsp1_valid !== re.port || rsp_data !== re.data || rsp_err !== re.err || cyc != re.cyc) begin
                        fails++;
                        $display("FAIL rsp got=p%0d/%h/e%0d@%0d expected=p%0d/%h/e%0d@%0d",
                                 rsp1_valid, rsp_data, rsp_err, cyc, re.port, re.data, re.err, re.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    int a0, a1, a2, a3;

    initial begin
        #1;
        chk("rst_ram_din", 32'(ram_din), 32'h0);
        chk("rst_ram_rx_valid", 32'(ram_rx_valid), 32'h0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both valid from reset, unlocked: grants alternate 0,1,0,1
        fork
            begin send(0, 10'h021, 1'b0, 1'b1, 8'h00, 1'b0, 3, a0);
                  send(0, 10'h022, 1'b0, 1'b1, 8'h00, 1'b0, 3, a2); end
            begin send(1, 10'h031, 1'b0, 1'b1, 8'h00, 1'b0, 3, a1);
                  send(1, 10'h032, 1'b0, 1'b1, 8'h00, 1'b0, 3, a3); end
        join
        chk("rr_grant1", 32'(a1 - a0), 32'd1);
        chk("rr_grant2", 32'(a2 - a0), 32'd2);
        chk("rr_grant3", 32'(a3 - a0), 32'd3);
        repeat (2) @(posedge clk);
        #1;

        // Locked address+data pair from req0, req1 waiting throughout
        fork
            begin send(0, 10'h012, 1'b1, 1'b1, 8'h00, 1'b0, 3, a0);
                  send(0, 10'h1AB, 1'b0, 1'b1, 8'h00, 1'b0, 3, a1); end
            begin send(1, 10'h034, 1'b0, 1'b1, 8'h00, 1'b0, 3, a2); end
        join
        chk("lock_b2b", 32'(a1 - a0), 32'd1);
        chk("lock_req1_after", 32'(a2 - a0), 32'd2);
        repeat (2) @(posedge clk);
        #1;

        // Locked read of mem[0x12]=0xAB, response to req0 three cycles after accept
        send(0, 10'h212, 1'b1, 1'b1, 8'h00, 1'b0, 3, a0);
        send(0, 10'h300, 1'b0, 1'b1, 8'hAB, 1'b0, 3, a1);
        chk("rd_b2b", 32'(a1 - a0), 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Reset while a read is in flight: outputs clear, no response, req0 wins next
        send(0, 10'h212, 1'b1, 1'b1, 8'h00, 1'b0, 3, a0);
        send(0, 10'h300, 1'b0, 1'b0, 8'h00, 1'b0, 3, a1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ram_rx_valid", 32'(ram_rx_valid), 32'h0);
        chk("midrst_ram_din", 32'(ram_din), 32'h0);
        chk("midrst_rsp_data", 32'(rsp_data), 32'h0);
        chk("midrst_rsp_valid", 32'({rsp0_valid, rsp1_valid, rsp_err}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            send(0, 10'h040, 1'b0, 1'b1, 8'h00, 1'b0, 3, a0);
            send(1, 10'h041, 1'b0, 1'b1, 8'h00, 1'b0, 3, a1);
        join
        chk("post_rst_req0_first", 32'(a1 - a0), 32'd1);
        repeat (8) @(posedge clk);
        #1;

`ifdef RAM_ARB_TIMEOUT_EN
        // Silent RAM: watchdog answers with rsp_err after four wait cycles
        ram_mute = 1'b1;
        send(0, 10'h212, 1'b1, 1'b1, 8'h00, 1'b0, 3, a0);
        send(0, 10'h300, 1'b0, 1'b1, 8'h00, 1'b1, 5, a1);
        repeat (8) @(posedge clk);
        #1;
        ram_mute = 1'b0;
        send(1, 10'h050, 1'b0, 1'b1, 8'h00, 1'b0, 3, a2);
        chk("wdog_idle_after", 32'(a2 > a1), 32'd1);
        repeat (4) @(posedge clk);
        #1;
`endif

        chk("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
